demux_serial_driver: RTL

//  Upstream feeder for the 1x4 demux stage: accepts parallel words tagged with a

---
 rtl/demux_serial_driver.sv | 78 +++++++
 1 files changed

// File: rtl/demux_serial_driver.sv
// demux_serial_driver: serializes channel-tagged words LSB-first onto a/sel for the 1x4 demux.
// Optional even-parity bit after the data bits when DEMUX_PARITY_EN is defined.
module demux_serial_driver #(
  parameter int DATA_W = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_ch,
  output logic [1:0]        sel,
  output logic              a,
  output logic              frame,
  output logic              done
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2;
`ifdef DEMUX_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(DATA_W);
  logic par;
`else
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
`endif
  logic [1:0]        st;
  logic [DATA_W-1:0] sh;
  logic [CW-1:0]     cnt;
  assign in_ready = st == IDLE;
  // sh holds only the bits not yet driven; a already carries the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      sel   <= 2'd0;
      a     <= IDLE_LEVEL;
      frame <= 1'b0;
      done  <= 1'b0;
`ifdef DEMUX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: if (in_valid) begin
          st    <= SHIFT;
          sh    <= in_data >> 1;
          sel   <= in_ch;
          cnt   <= '0;
          a     <= in_data[0];
          frame <= 1'b1;
`ifdef DEMUX_PARITY_EN
          par   <= ^in_data;
`endif
        end
        SHIFT: if (cnt == LAST) begin
          st    <= GAP;
          a     <= IDLE_LEVEL;
          frame <= 1'b0;
          done  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          sh  <= sh >> 1;
`ifdef DEMUX_PARITY_EN
          a   <= cnt == CW'(DATA_W - 1) ? par : sh[0];
`else
          a   <= sh[0];
`endif
        end
        GAP: begin
          st   <= IDLE;
          done <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
